// File: rtl/connect4_pkg.sv
// Shared types and default dimensions for the Connect-4 turn controller.
package connect4_pkg;

    localparam int C4_COLS = 7;
    localparam int C4_ROWS = 6;
    localparam int C4_CW   = $clog2(C4_COLS);
    localparam int C4_RW   = $clog2(C4_ROWS + 1);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        WAIT  = 2'd1,
        PLACE = 2'd2,
        FULL  = 2'd3
    } turn_state_t;

    typedef logic player_t;

endpackage

// File: rtl/connect4_col_heights.sv
// Per-column stack heights, per-column full flags and the lowest
// non-full column encoder used by the automatic timeout move.
module connect4_col_heights
    import connect4_pkg::*;
#(
    parameter int COLS = C4_COLS,
    parameter int ROWS = C4_ROWS,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_en,
    input  logic [CW-1:0]      inc_col,
    output logic [COLS*RW-1:0] heights,
    output logic [COLS-1:0]    col_full,
    output logic [CW-1:0]      free_col
);

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [RW-1:0] h_q;
            logic [RW-1:0] h_d;

            // Saturate at ROWS so a stray increment can never wrap a full column.
            always_comb begin
                h_d = h_q;
                if (inc_en && (inc_col == CW'(gi)) && (h_q != RW'(ROWS))) begin
                    h_d = h_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    h_q <= '0;
                end else begin
                    h_q <= h_d;
                end
            end

            assign heights[gi*RW +: RW] = h_q;
            assign col_full[gi]         = (h_q == RW'(ROWS));
        end
    endgenerate

    always_comb begin
        free_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_full[i]) begin
                free_col = CW'(i);
            end
        end
    end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 turn sequencer: arms the turn timer, accepts moves, emits placements.
// Optional build macro C4_AUTO_MOVE_EN: a timeout auto-places in the lowest free column.
module connect4_turn_ctrl
    import connect4_pkg::*;
#(
    parameter int COLS = C4_COLS,
    parameter int ROWS = C4_ROWS,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move_valid,
    input  logic [CW-1:0] move_col,
    output logic          move_ready,
    input  logic          timer_done,
    output logic          timer_start,
    output logic          place_valid,
    output logic [CW-1:0] place_col,
    output logic [RW-1:0] place_row,
    output logic          place_player,
    output logic          cur_player,
    output logic          move_err,
    output logic          timeout,
    output logic          board_full
);

    localparam int                CNTW  = $clog2(ROWS * COLS + 1);
    localparam int                CPAD  = 1 << CW;
    localparam logic [CNTW-1:0]   CELLS = CNTW'(ROWS * COLS);

    turn_state_t     state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    player_t         cur_player_q, cur_player_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            move_err_q, move_err_d;
    logic            timeout_q, timeout_d;
    logic            init_q, init_d;
`ifdef C4_AUTO_MOVE_EN
    logic            auto_pend_q, auto_pend_d;
`endif

    logic               inc_en;
    logic [COLS*RW-1:0] heights;
    logic [COLS-1:0]    col_full;
    logic [CPAD-1:0]    full_pad;
    logic [CW-1:0]      free_col;
    logic [RW-1:0]      sel_h;
    logic               col_illegal;

    connect4_col_heights #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_heights (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (inc_en),
        .inc_col  (col_q),
        .heights  (heights),
        .col_full (col_full),
        .free_col (free_col)
    );

`ifndef C4_AUTO_MOVE_EN
    logic unused_free;
    assign unused_free = ^free_col;
`endif

    // Pad the full flags so out-of-range column indices select a defined bit.
    assign full_pad    = CPAD'(col_full);
    assign col_illegal = ({1'b0, move_col} >= (CW + 1)'(COLS)) || full_pad[move_col];
    assign sel_h       = heights[col_q*RW +: RW];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cur_player_d = cur_player_q;
        count_d      = count_q;
        move_err_d   = 1'b0;
        timeout_d    = 1'b0;
        init_d       = 1'b1;
        inc_en       = 1'b0;
`ifdef C4_AUTO_MOVE_EN
        auto_pend_d  = auto_pend_q;
`endif
        case (state_q)
            // The first cycle after reset only primes init_q, so the timer
            // pulse lands in the first full cycle after release.
            ARM: begin
                if (init_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef C4_AUTO_MOVE_EN
                if (auto_pend_q) begin
                    auto_pend_d = 1'b0;
                    col_d       = free_col;
                    state_d     = PLACE;
                end else
`endif
                if (move_valid) begin
                    if (col_illegal) begin
                        move_err_d = 1'b1;
                    end else begin
                        col_d   = move_col;
                        state_d = PLACE;
                    end
                end else if (timer_done) begin
                    timeout_d = 1'b1;
`ifdef C4_AUTO_MOVE_EN
                    auto_pend_d = 1'b1;
`else
                    cur_player_d = ~cur_player_q;
                    state_d      = ARM;
`endif
                end
            end
            PLACE: begin
                inc_en       = 1'b1;
                count_d      = count_q + 1'b1;
                cur_player_d = ~cur_player_q;
                state_d      = (count_d == CELLS) ? FULL : ARM;
            end
            FULL: begin
                state_d = FULL;
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARM;
            col_q        <= '0;
            cur_player_q <= 1'b0;
            count_q      <= '0;
            move_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            init_q       <= 1'b0;
`ifdef C4_AUTO_MOVE_EN
            auto_pend_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cur_player_q <= cur_player_d;
            count_q      <= count_d;
            move_err_q   <= move_err_d;
            timeout_q    <= timeout_d;
            init_q       <= init_d;
`ifdef C4_AUTO_MOVE_EN
            auto_pend_q  <= auto_pend_d;
`endif
        end
    end

`ifdef C4_AUTO_MOVE_EN
    assign move_ready = (state_q == WAIT) && !auto_pend_q;
`else
    assign move_ready = (state_q == WAIT);
`endif
    assign timer_start  = (state_q == ARM) && init_q;
    assign place_valid  = (state_q == PLACE);
    assign place_col    = place_valid ? col_q : '0;
    assign place_row    = place_valid ? sel_h : '0;
    assign place_player = place_valid & cur_player_q;
    assign cur_player   = cur_player_q;
    assign move_err     = move_err_q;
    assign timeout      = timeout_q;
    assign board_full   = (state_q == FULL);

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Scoreboard bench for connect4_turn_ctrl: expected events are queued when a
// move or timeout is driven and popped when the DUT pulses an event output.
module tb_connect4_turn_ctrl;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_valid;
    logic [2:0] move_col;
    logic       move_ready;
    logic       timer_done;
    logic       timer_start;
    logic       place_valid;
    logic [2:0] place_col;
    logic [2:0] place_row;
    logic       place_player;
    logic       cur_player;
    logic       move_err;
    logic       timeout;
    logic       board_full;

    connect4_turn_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .move_valid   (move_valid),
        .move_col     (move_col),
        .move_ready   (move_ready),
        .timer_done   (timer_done),
        .timer_start  (timer_start),
        .place_valid  (place_valid),
        .place_col    (place_col),
        .place_row    (place_row),
        .place_player (place_player),
        .cur_player   (cur_player),
        .move_err     (move_err),
        .timeout      (timeout),
        .board_full   (board_full)
    );

    always #10 clk = ~clk;

    typedef struct {
        int kind;   // 1 place, 2 error, 3 timeout
        int col;
        int row;
        int player;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    int  h_m[COLS];
    int  player_m;
    int  count_m;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (place_valid || move_err || timeout)) begin
            int  kind;
            ev_t e;
            kind = place_valid ? 1 : (move_err ? 2 : 3);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", kind, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind", kind, e.kind);
                if (e.kind == 1) begin
                    chk("place_col", int'(place_col), e.col);
                    chk("place_row", int'(place_row), e.row);
                    chk("place_player", int'(place_player), e.player);
                end
                $display("event kind=%0d col=%0d row=%0d player=%0d", kind,
                         place_col, place_row, place_player);
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < COLS; i++) h_m[i] = 0;
        player_m = 0;
        count_m  = 0;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < COLS; i++) begin
            if (h_m[i] < ROWS) return i;
        end
        return 0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!move_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!move_ready) chk("ready_wait_expired", 0, 1);
    endtask

    task automatic push_place(input int col);
        ev_t e;
        e.kind = 1; e.col = col; e.row = h_m[col]; e.player = player_m;
        exp_q.push_back(e);
        h_m[col]++;
        player_m ^= 1;
        count_m++;
    endtask

    task automatic do_move(input int col, input bit with_timer);
        bit  legal;
        ev_t e;
        wait_ready();
        legal = (col < COLS) && (h_m[col] < ROWS);
        if (legal) begin
            push_place(col);
        end else begin
            e.kind = 2; e.col = 0; e.row = 0; e.player = 0;
            exp_q.push_back(e);
        end
        move_valid = 1'b1;
        move_col   = 3'(col);
        timer_done = with_timer;
        @(negedge clk);
        move_valid = 1'b0;
        timer_done = 1'b0;
        if (legal) begin
            @(negedge clk);
            chk("tstart_after_move", int'(timer_start), (count_m == ROWS * COLS) ? 0 : 1);
            chk("player_after_move", int'(cur_player), player_m);
            chk("full_after_move", int'(board_full), (count_m == ROWS * COLS) ? 1 : 0);
        end else begin
            chk("ready_after_err", int'(move_ready), 1);
            chk("player_after_err", int'(cur_player), player_m);
        end
    endtask

    task automatic do_timeout();
        ev_t e;
        wait_ready();
        e.kind = 3; e.col = 0; e.row = 0; e.player = 0;
        exp_q.push_back(e);
`ifdef C4_AUTO_MOVE_EN
        push_place(lowest_free());
`else
        player_m ^= 1;
`endif
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
`ifdef C4_AUTO_MOVE_EN
        @(negedge clk);
        @(negedge clk);
`endif
        chk("tstart_after_timeout", int'(timer_start), 1);
        chk("player_after_timeout", int'(cur_player), player_m);
    endtask

    initial begin
        rst        = 1'b1;
        move_valid = 1'b0;
        move_col   = '0;
        timer_done = 1'b0;
        reset_model();

        @(negedge clk);
        @(negedge clk);
        chk("rst_tstart", int'(timer_start), 0);
        chk("rst_ready", int'(move_ready), 0);
        chk("rst_place", int'(place_valid), 0);
        chk("rst_player", int'(cur_player), 0);
        chk("rst_full", int'(board_full), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_tstart1", int'(timer_start), 1);
        chk("rel_ready1", int'(move_ready), 0);
        @(negedge clk);
        chk("rel_tstart2", int'(timer_start), 0);
        chk("rel_ready2", int'(move_ready), 1);
        chk("rel_err", int'(move_err), 0);
        chk("rel_timeout", int'(timeout), 0);

        do_move(3, 1'b0);
        do_move(3, 1'b0);
        for (int i = 0; i < ROWS; i++) do_move(0, 1'b0);
        do_move(0, 1'b0);
        do_move(7, 1'b0);
        do_timeout();
        do_move(2, 1'b1);
        do_move(7, 1'b1);

        // Reset arriving while a placement is on the outputs.
        wait_ready();
        push_place(4);
        move_valid = 1'b1;
        move_col   = 3'd4;
        @(negedge clk);
        move_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("rst_mid_place", int'(place_valid), 0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tstart", int'(timer_start), 1);
        do_move(4, 1'b0);
        do_move(3, 1'b0);

        while (count_m < ROWS * COLS) do_move(lowest_free(), 1'b0);
        chk("full_flag", int'(board_full), 1);
        chk("full_ready", int'(move_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            timer_done = 1'b1;
            move_valid = (i == 1);
            move_col   = 3'd6;
            @(negedge clk);
            timer_done = 1'b0;
            move_valid = 1'b0;
            chk("full_tstart", int'(timer_start), 0);
            chk("full_sticky", int'(board_full), 1);
        end
        repeat (3) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
